// File: rtl/alu_op_arbiter_pkg.sv
// Shared types and constants for the ALU operation arbiter: FSM states,
// op-select encodings, operand/result widths and the sign-magnitude helper.
package alu_op_arbiter_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;
    localparam int unsigned N_REQ = 2;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Two's-complement magnitude; 0x80 maps to 128, which still fits 8 bits unsigned.
    function automatic logic [OP_W-1:0] mag8(input logic [OP_W-1:0] x);
        return x[OP_W-1] ? OP_W'(~x + OP_W'(1)) : x;
    endfunction

endpackage

// File: rtl/alu_op_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot combinational grant, pointer moves to
// the other requester whenever a grant is actually transferred.
module rr_arbiter2
    import alu_op_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             xfer,
    output logic [N_REQ-1:0] grant_c
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = grant_c[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_op_arbiter.sv
// Arbitrates switch-panel and UART requests onto a shared mul/div datapath.
// Define ALU_OP_ARBITER_TIMEOUT_EN to add a RUN-state timeout counter.
module alu_op_arbiter
    import alu_op_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    input  logic [N_REQ-1:0]      req_div,
    output logic                  dp_start,
    output logic [OP_W-1:0]       dp_a,
    output logic [OP_W-1:0]       dp_b,
    output logic                  dp_div,
    input  logic                  dp_done,
    input  logic [RES_W-1:0]      dp_p,
    output logic                  dp_abort,
    input  logic                  rsp_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [RES_W-1:0]      rsp_p,
    output logic                  rsp_neg,
    output logic                  rsp_err
);

    state_e            state_q, state_d;
    logic              dp_start_q, dp_start_d;
    logic              dp_abort_q, dp_abort_d;
    logic [OP_W-1:0]   dp_a_q, dp_a_d;
    logic [OP_W-1:0]   dp_b_q, dp_b_d;
    logic              dp_div_q, dp_div_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]  rsp_p_q, rsp_p_d;
    logic              rsp_neg_q, rsp_neg_d;
    logic              rsp_err_q, rsp_err_d;
    logic              abort_pend_q, abort_pend_d;

    logic [N_REQ-1:0]  grant_c;
    logic              xfer_c;
    logic              win_c;
    logic [OP_W-1:0]   sel_a_c;
    logic [OP_W-1:0]   sel_b_c;
    logic              sel_div_c;

`ifdef ALU_OP_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .xfer    (xfer_c),
        .grant_c (grant_c)
    );

    // Ready is the live grant so the handshake completes in the IDLE cycle itself.
    assign req_ready = (state_q == IDLE && !rst) ? grant_c : '0;
    assign xfer_c    = |(req_ready & req_valid);
    assign win_c     = grant_c[1];
    assign sel_a_c   = win_c ? req_a[2*OP_W-1:OP_W] : req_a[OP_W-1:0];
    assign sel_b_c   = win_c ? req_b[2*OP_W-1:OP_W] : req_b[OP_W-1:0];
    assign sel_div_c = win_c ? req_div[1] : req_div[0];

    always_comb begin
        state_d      = state_q;
        dp_start_d   = 1'b0;
        dp_abort_d   = 1'b0;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        dp_div_d     = dp_div_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_p_d      = rsp_p_q;
        rsp_neg_d    = rsp_neg_q;
        rsp_err_d    = rsp_err_q;
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        // An op cut short by reset must be aborted once reset lets go.
        abort_pend_d = rst & (abort_pend_q | (state_q == RUN));
        if (!rst && abort_pend_q) begin
            dp_abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    dp_a_d    = mag8(sel_a_c);
                    dp_b_d    = mag8(sel_b_c);
                    dp_div_d  = sel_div_c;
                    rsp_neg_d = sel_a_c[OP_W-1] ^ sel_b_c[OP_W-1];
                    rsp_id_d  = win_c;
                    rsp_p_d   = '0;
                    rsp_err_d = 1'b0;
                    if (sel_div_c == OP_DIV && sel_b_c == '0) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        dp_start_d = 1'b1;
                        state_d    = RUN;
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            RUN: begin
                if (dp_done) begin
                    rsp_p_d     = dp_p;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    dp_abort_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_p_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        abort_pend_q <= abort_pend_d;
        if (rst) begin
            state_q     <= IDLE;
            dp_start_q  <= 1'b0;
            dp_abort_q  <= 1'b0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_div_q    <= OP_MUL;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_p_q     <= '0;
            rsp_neg_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dp_start_q  <= dp_start_d;
            dp_abort_q  <= dp_abort_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            dp_div_q    <= dp_div_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            rsp_neg_q   <= rsp_neg_d;
            rsp_err_q   <= rsp_err_d;
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign dp_start  = dp_start_q;
    assign dp_abort  = dp_abort_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_div    = dp_div_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_neg   = rsp_neg_q;
    assign rsp_err   = rsp_err_q;

endmodule
